mul4_fitness_scorer: RTL and testbench

//   Downstream scoring stage for an evolved bit-sliced 2x2-bit multiplier individual.
//   - Each 16-bit bus carries one bit for 16 parallel lanes.
//   - Per lane i: a={a1[i],a0[i]}, b={b1[i],b0[i]}, candidate product {y3[i],y2[i],y1[i],y0[i]}.
//   - Captures one operand/result vector set, walks the lanes sequentially and compares each

---
 rtl/mul4_score_pkg.sv | 21 ++
 rtl/mul4_lane_cmp.sv | 25 ++
 rtl/mul4_fitness_scorer.sv | 170 +++++++++++++++++
 tb/tb_mul4_fitness_scorer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mul4_score_pkg.sv
// mul4_score_pkg
//   Shared definitions for the 2x2-bit multiplier fitness scorer.
//   - LANES_DEFAULT : default lane count (width of every bit-sliced bus)
//   - state_e       : scorer FSM encoding {IDLE, SCORE, DONE}
//   - exp_prod()    : exact 4-bit product of two 2-bit unsigned operands
package mul4_score_pkg;

  localparam int LANES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCORE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // 3*3 = 9 is the largest product, so four bits hold it without truncation.
  function automatic logic [3:0] exp_prod(input logic [1:0] a, input logic [1:0] b);
    return {2'b00, a} * {2'b00, b};
  endfunction

endpackage

// File: rtl/mul4_lane_cmp.sv
// mul4_lane_cmp
//   Combinational scorer for a single lane: compares a candidate 4-bit product
//   against the exact product of the lane's operands.
//   Ports:
//     a, b       in  2  lane operands
//     y          in  4  candidate product
//     match_cnt  out 3  number of candidate bits equal to the exact product (0..4)
//     exact      out 1  all four bits match
module mul4_lane_cmp
  import mul4_score_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [3:0] y,
  output logic [2:0] match_cnt,
  output logic       exact
);

  logic [3:0] agree;

  assign agree     = ~(exp_prod(a, b) ^ y);
  assign match_cnt = 3'(agree[0]) + 3'(agree[1]) + 3'(agree[2]) + 3'(agree[3]);
  assign exact     = &agree;

endmodule

// File: rtl/mul4_fitness_scorer.sv
// mul4_fitness_scorer
//   Captures one bit-sliced operand/result vector set, walks its lanes
//   LANES_PER_CYCLE at a time, and reports a fitness record over valid/ready.
//   Lane i: a = {a1[i],a0[i]}, b = {b1[i],b0[i]}, y = {y3[i],y2[i],y1[i],y0[i]}.
//
//   Ports:
//     clk, rst             clock; asynchronous active-high reset
//     in_valid / in_ready  vector-set handshake (accepted only in IDLE)
//     a1,a0,b1,b0          bit-sliced operands, LANES wide
//     y3,y2,y1,y0          bit-sliced candidate product, LANES wide
//     out_valid/out_ready  fitness-record handshake (out_ready only matters in DONE)
//     bits_ok              product bits matching the exact product (0..4*LANES)
//     lanes_ok             lanes whose whole product is exact (0..LANES)
//     perfect              bits_ok == 4*LANES
//     mismatch_mask        (only with MUL4_SCORER_MISMATCH_MASK_EN) bit i set when lane i
//                          is not exact
//
//   State | Meaning
//   ------+----------------------------------------------------------
//   IDLE  | ready for a vector set; last record stays on the outputs
//   SCORE | scoring one lane group per cycle from the captured copy
//   DONE  | record valid and frozen until out_ready
module mul4_fitness_scorer
  import mul4_score_pkg::*;
#(
  parameter int LANES           = LANES_DEFAULT,
  parameter int LANES_PER_CYCLE = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [LANES-1:0]               a1,
  input  logic [LANES-1:0]               a0,
  input  logic [LANES-1:0]               b1,
  input  logic [LANES-1:0]               b0,
  input  logic [LANES-1:0]               y3,
  input  logic [LANES-1:0]               y2,
  input  logic [LANES-1:0]               y1,
  input  logic [LANES-1:0]               y0,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(4*LANES+1)-1:0]   bits_ok,
  output logic [$clog2(LANES+1)-1:0]     lanes_ok,
  output logic                           perfect
`ifdef MUL4_SCORER_MISMATCH_MASK_EN
  ,
  output logic [LANES-1:0]               mismatch_mask
`endif
);

  localparam int BITS_W   = $clog2(4*LANES+1);
  localparam int LANE_W   = $clog2(LANES+1);
  localparam int IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LAST_IDX = LANES - LANES_PER_CYCLE;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SCORE = SCORE;
  localparam logic [1:0] S_DONE  = DONE;

  generate
    if (LANES_PER_CYCLE < 1 || (LANES % LANES_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("mul4_fitness_scorer: LANES_PER_CYCLE must divide LANES");
    end
  endgenerate

  logic [1:0]       state;
  logic [IDX_W-1:0] lane_idx;
  logic [LANES-1:0] cap_a1, cap_a0, cap_b1, cap_b0;
  logic [LANES-1:0] cap_y3, cap_y2, cap_y1, cap_y0;

  logic [IDX_W-1:0] grp_idx   [LANES_PER_CYCLE];
  logic [2:0]       grp_match [LANES_PER_CYCLE];
  logic             grp_exact [LANES_PER_CYCLE];
  logic [BITS_W-1:0] grp_bits;
  logic [LANE_W-1:0] grp_lanes;

  generate
    for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
      assign grp_idx[g] = lane_idx + IDX_W'(g);

      mul4_lane_cmp u_cmp (
        .a         ({cap_a1[grp_idx[g]], cap_a0[grp_idx[g]]}),
        .b         ({cap_b1[grp_idx[g]], cap_b0[grp_idx[g]]}),
        .y         ({cap_y3[grp_idx[g]], cap_y2[grp_idx[g]],
                     cap_y1[grp_idx[g]], cap_y0[grp_idx[g]]}),
        .match_cnt (grp_match[g]),
        .exact     (grp_exact[g])
      );
    end
  endgenerate

  always_comb begin
    grp_bits  = '0;
    grp_lanes = '0;
    for (int k = 0; k < LANES_PER_CYCLE; k++) begin
      grp_bits  = grp_bits + BITS_W'(grp_match[k]);
      grp_lanes = grp_lanes + LANE_W'(grp_exact[k]);
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign perfect   = (bits_ok == BITS_W'(4*LANES));

`ifdef MUL4_SCORER_MISMATCH_MASK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_mask <= '0;
    end else if (state == S_IDLE && in_valid) begin
      mismatch_mask <= '0;
    end else if (state == S_SCORE) begin
      for (int k = 0; k < LANES_PER_CYCLE; k++) begin
        mismatch_mask[grp_idx[k]] <= ~grp_exact[k];
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      lane_idx <= '0;
      bits_ok  <= '0;
      lanes_ok <= '0;
      cap_a1   <= '0;
      cap_a0   <= '0;
      cap_b1   <= '0;
      cap_b0   <= '0;
      cap_y3   <= '0;
      cap_y2   <= '0;
      cap_y1   <= '0;
      cap_y0   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            cap_a1   <= a1;
            cap_a0   <= a0;
            cap_b1   <= b1;
            cap_b0   <= b0;
            cap_y3   <= y3;
            cap_y2   <= y2;
            cap_y1   <= y1;
            cap_y0   <= y0;
            bits_ok  <= '0;
            lanes_ok <= '0;
            lane_idx <= '0;
            state    <= S_SCORE;
          end
        end
        S_SCORE: begin
          bits_ok  <= bits_ok + grp_bits;
          lanes_ok <= lanes_ok + grp_lanes;
          if (lane_idx == IDX_W'(LAST_IDX)) begin
            lane_idx <= '0;
            state    <= S_DONE;
          end else begin
            lane_idx <= lane_idx + IDX_W'(LANES_PER_CYCLE);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul4_fitness_scorer.sv
// tb_mul4_fitness_scorer
//   Directed bench for mul4_fitness_scorer with hand-computed fitness records.
//   Operands fixed at a1=FF00 a0=F0F0 b1=CCCC b0=AAAA, so lane i has a=i[3:2], b=i[1:0].
//   Exact products per lane: 0,0,0,0, 0,1,2,3, 0,2,4,6, 0,3,6,9
//   -> y3=8000 y2=4C00 y1=6AC0 y0=A0A0.
//   Define MUL4_SCORER_MISMATCH_MASK_EN to also exercise mismatch_mask.
module tb_mul4_fitness_scorer;

  localparam logic [15:0] A1 = 16'hFF00, A0 = 16'hF0F0, B1 = 16'hCCCC, B0 = 16'hAAAA;
  localparam logic [15:0] EY3 = 16'h8000, EY2 = 16'h4C00, EY1 = 16'h6AC0, EY0 = 16'hA0A0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
  logic        out_valid, out_ready;
  logic [6:0]  bits_ok;
  logic [4:0]  lanes_ok;
  logic        perfect;
`ifdef MUL4_SCORER_MISMATCH_MASK_EN
  logic [15:0] mismatch_mask;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cnt;

  always #5 clk = ~clk;

  mul4_fitness_scorer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a1        (a1),
    .a0        (a0),
    .b1        (b1),
    .b0        (b0),
    .y3        (y3),
    .y2        (y2),
    .y1        (y1),
    .y0        (y0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bits_ok   (bits_ok),
    .lanes_ok  (lanes_ok),
    .perfect   (perfect)
`ifdef MUL4_SCORER_MISMATCH_MASK_EN
    ,
    .mismatch_mask (mismatch_mask)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_set(input logic [15:0] v3, v2, v1, v0);
    a1 = A1; a0 = A0; b1 = B1; b0 = B0;
    y3 = v3; y2 = v2; y1 = v1; y0 = v0;
  endtask

  task automatic scramble();
    a1 = 16'($urandom); a0 = 16'($urandom); b1 = 16'($urandom); b0 = 16'($urandom);
    y3 = 16'($urandom); y2 = 16'($urandom); y1 = 16'($urandom); y0 = 16'($urandom);
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_latency"}, cnt, exp_lat);
  endtask

  task automatic check_rec(input string tag, input int eb, input int el, input logic ep,
                           input logic [15:0] em);
    chk({tag, "_bits_ok"}, bits_ok, eb);
    chk({tag, "_lanes_ok"}, lanes_ok, el);
    chk({tag, "_perfect"}, perfect, ep);
`ifdef MUL4_SCORER_MISMATCH_MASK_EN
    chk({tag, "_mask"}, mismatch_mask, em);
`else
    if (em === 16'hxxxx) $display("unused mask argument");
`endif
  endtask

  // Called #1 after a rising edge with the scorer in IDLE.
  task automatic run_set(input string tag, input logic [15:0] v3, v2, v1, v0,
                         input int eb, input int el, input logic ep, input logic [15:0] em);
    drive_set(v3, v2, v1, v0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    chk({tag, "_in_ready_score"}, in_ready, 1'b0);
    wait_valid(tag, 16);
    check_rec(tag, eb, el, ep, em);
    @(posedge clk); #1;
    chk({tag, "_out_valid_after"}, out_valid, 1'b0);
    chk({tag, "_in_ready_after"}, in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive_set(16'h0, 16'h0, 16'h0, 16'h0);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    check_rec("rst", 0, 0, 1'b0, 16'h0000);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run_set("exact", EY3, EY2, EY1, EY0, 64, 16, 1'b1, 16'h0000);
    run_set("zeros", 16'h0, 16'h0, 16'h0, 16'h0, 50, 7, 1'b0, 16'hEEE0);
    run_set("ones", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 14, 0, 1'b0, 16'hFFFF);
    run_set("lane0_bad", EY3, EY2, EY1, EY0 | 16'h0001, 63, 15, 1'b0, 16'h0001);

    // Back-pressure: record frozen while out_ready is low.
    drive_set(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    wait_valid("bp", 16);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid_hold", out_valid, 1'b1);
      chk("bp_in_ready_hold", in_ready, 1'b0);
      check_rec("bp_hold", 14, 0, 1'b0, 16'hFFFF);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_out_valid_after", out_valid, 1'b0);
    chk("bp_in_ready_after", in_ready, 1'b1);

    // in_valid held across two sets: exact first, then all-zero candidate.
    drive_set(EY3, EY2, EY1, EY0);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    drive_set(16'h0, 16'h0, 16'h0, 16'h0);
    wait_valid("iv_first", 16);
    check_rec("iv_first", 64, 16, 1'b1, 16'h0000);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (out_valid && cnt < 50);
    while (!out_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("iv_gap", cnt, 18);
    in_valid = 1'b0;
    check_rec("iv_second", 50, 7, 1'b0, 16'hEEE0);
    @(posedge clk); #1;
    chk("iv_in_ready_after", in_ready, 1'b1);

    // Asynchronous reset in the middle of SCORE.
    drive_set(EY3, EY2, EY1, EY0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_bits_partial", bits_ok, 32);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    check_rec("mid_rst", 0, 0, 1'b0, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    run_set("post_rst", 16'h0, 16'h0, 16'h0, 16'h0, 50, 7, 1'b0, 16'hEEE0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
